frame_buf_sched: RTL and testbench
==================================

# frame_buf_sched

Ping-pong scheduler for a two-bank frame buffer, all in the `wr_clk` domain. A producer fills one bank while a consumer drains the other, and the banks swap when a full frame completes. The block owns every memory enable and address: it accepts or stalls word requests from both sides and never lets a bank be overwritten before it has been read. It sits between the pixel source/sink and the shared dual-port data memory, and carries no data itself.

## Interface
- `ADDR_WIDTH`, 9: word address width within one bank. Requirement: `BUF_SIZE <= 2**ADDR_WIDTH`.
- `BUF_SIZE`, 500: words per frame; must be >= 1.
- `wr_clk`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high; sampled on the rising edge of `wr_clk`.
- `wr_req`  in  1: producer presents a word this cycle.
- `wr_restart`  in  1: discard the partial frame in the current write bank.
- `rd_req`  in  1: consumer wants a word this cycle.
- `wr_ack`  out  1: write word accepted this cycle (combinational).
- `rd_ack`  out  1: read issued this cycle (combinational).
- `mem_wr_en`  out  1: equals `wr_ack`.
- `mem_wr_addr`  out  ADDR_WIDTH+1: `{wr_buf, wr_cnt}`.
- `mem_rd_en`  out  1: equals `rd_ack`.
- `mem_rd_addr`  out  ADDR_WIDTH+1: `{rd_buf, rd_cnt}`.
- `wr_frame_done`  out  1: one-cycle registered pulse after the last word of a frame is written.
- `rd_frame_done`  out  1: one-cycle registered pulse after the last word of a frame is read.
- `full_cnt`  out  2: number of FULL banks (0–2).

## Operation
- **Bank flags:** `full[1:0]` marks each bank EMPTY (0) or FULL (1). The bank pointers `wr_buf` and `rd_buf` are 1 bit each. The word counters `wr_cnt` and `rd_cnt` are ADDR_WIDTH bits and count 0..BUF_SIZE-1.
- **Writer FSM:**
  - W_FILL → W_BLOCK when a frame completes into a bank whose new `wr_buf` target has `full` = 1.
  - W_BLOCK → W_FILL on the edge where `full[wr_buf]` is seen 0.
  - `wr_ack = wr_req & (state == W_FILL) & ~full[wr_buf] & ~wr_restart`.
- **Write advance:** on an edge with `wr_ack`, `wr_cnt` increments. At `wr_cnt == BUF_SIZE-1`, that edge also:
  - wraps `wr_cnt` to 0,
  - sets `full[wr_buf]`,
  - toggles `wr_buf`,
  - asserts `wr_frame_done` for the next cycle.
- **Restart:** `wr_restart` clears `wr_cnt` to 0 and leaves `wr_buf` and `full` unchanged. It overrides a simultaneous `wr_req`, so no ack and no done pulse are produced.
- **Reader FSM:**
  - R_IDLE → R_DRAIN on an edge where `full[rd_buf]` = 1.
  - `rd_ack = rd_req & (state == R_DRAIN)`.
  - On an edge with `rd_ack` and `rd_cnt == BUF_SIZE-1`: wrap `rd_cnt` to 0, clear `full[rd_buf]`, toggle `rd_buf`, assert `rd_frame_done` for the next cycle, and return to R_IDLE.
  - Otherwise `rd_cnt` increments on each `rd_ack` edge.
- **Simultaneous set and clear:** if the writer sets one bank and the reader clears the other on the same edge, both updates apply. `full_cnt` is unchanged.
- **Ordering:** because of the pointer discipline the writer and reader can never target the same bank at the same time. An assertion checks that `wr_ack & rd_ack & (wr_buf == rd_buf)` never occurs.
- **No drop policy:** the producer is stalled, never overwritten. The consumer simply waits in R_IDLE.
- **BUF_SIZE = 1:** every ack is also the last-word event.

## Timing
- **Reset values:**
  - `wr_buf` = `rd_buf` = 0, `wr_cnt` = `rd_cnt` = 0, `full` = 00.
  - Writer in W_FILL, reader in R_IDLE.
  - `wr_frame_done` = `rd_frame_done` = 0, `full_cnt` = 0.
  - `wr_ack` = `rd_ack` = 0 while `reset` is high.
- **Reset mid-frame:** all partial frames and flags are discarded with no done pulse. The first ack is possible in the cycle after `reset` deasserts.
- **Write to read:** if the last write ack occurs in cycle N:
  - `wr_frame_done` and the `full` update are visible in N+1,
  - the reader enters R_DRAIN at the end of N+1,
  - the first `rd_ack` is possible in N+2.
- **Read to unblock:** if the last read ack occurs in cycle M:
  - the `full` bit is clear in M+1,
  - a blocked writer leaves W_BLOCK at the end of M+1,
  - the first `wr_ack` is possible in M+2.
- **Throughput:** steady-state throughput is one word per cycle per side. There are no bubbles inside a frame.
- **Read data latency:** memory read data latency belongs to the memory. This block adds none beyond the combinational `rd_ack`.

## Test plan
Bench parameters: ADDR_WIDTH = 2, BUF_SIZE = 4.
1. **Fill after reset:** reset, then `wr_req` held for 4 cycles.
   - `mem_wr_addr` = 0, 1, 2, 3.
   - `wr_frame_done` pulses in cycle 5; `full_cnt` = 1.
   - `rd_ack` is first possible in cycle 6, at `mem_rd_addr` = 0.
2. **Writer stalls, no overwrite:** `wr_req` held for 10 cycles, `rd_req` low.
   - Addresses 0–3 then 4–7 are acked, then `wr_ack` stays 0 in W_BLOCK.
   - `full_cnt` = 2 and no address repeats.
3. **Unblock:** from state 2, `rd_req` held.
   - Reads 0–3 are issued, `rd_frame_done` pulses, then reads 4–7.
   - The writer resumes at address 0 two cycles after read 3 is acked.
4. **Simultaneous completion:** arrange the last write into bank 1 and the last read from bank 0 on the same edge.
   - Both done pulses fire together; `full` = 10 and `full_cnt` = 1.
5. **Restart:** write 2 words, assert `wr_restart` together with `wr_req`.
   - No ack that cycle.
   - The next write goes to address 0 of the same bank; no done pulse.
6. **Reset mid-operation:** assert `reset` during a read frame.
   - All outputs return to their reset values the next cycle.
   - The next frame's writes start at address 0.

Source files
------------

// File: rtl/frame_buf_sched.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_sched
// Description : Ping-pong scheduler for a two-bank frame buffer; owns the
//               memory enables/addresses and stalls the producer on full banks.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buf_sched #(
    parameter int ADDR_WIDTH = 9,
    parameter int BUF_SIZE   = 500
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic                  wr_restart,
    input  logic                  rd_req,
    output logic                  wr_ack,
    output logic                  rd_ack,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH:0]   mem_wr_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH:0]   mem_rd_addr,
    output logic                  wr_frame_done,
    output logic                  rd_frame_done,
    output logic [1:0]            full_cnt
);

    typedef enum logic [0:0] {W_FILL = 1'b0, W_BLOCK = 1'b1} wr_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DRAIN = 1'b1} rd_state_t;

    localparam logic [ADDR_WIDTH-1:0] c_last = ADDR_WIDTH'(BUF_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] c_one  = ADDR_WIDTH'(1);

    wr_state_t              r_wr_state, w_wr_state_nxt;
    rd_state_t              r_rd_state, w_rd_state_nxt;
    logic [1:0]             r_full;
    logic                   r_wr_buf, r_rd_buf;
    logic [ADDR_WIDTH-1:0]  r_wr_cnt, r_rd_cnt;
    logic                   r_wr_done, r_rd_done;
    logic                   w_wr_ack, w_rd_ack, w_wr_last, w_rd_last;

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_wr_state <= W_FILL;
            r_rd_state <= R_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    // Acks are forced low while reset is asserted so no access leaks out.
    always_comb begin
        w_wr_ack       = wr_req & (r_wr_state == W_FILL) & ~r_full[r_wr_buf]
                         & ~wr_restart & ~reset;
        w_rd_ack       = rd_req & (r_rd_state == R_DRAIN) & ~reset;
        w_wr_last      = w_wr_ack & (r_wr_cnt == c_last);
        w_rd_last      = w_rd_ack & (r_rd_cnt == c_last);
        w_wr_state_nxt = r_wr_state;
        w_rd_state_nxt = r_rd_state;
        case (r_wr_state)
            W_FILL:  if (w_wr_last && r_full[~r_wr_buf]) w_wr_state_nxt = W_BLOCK;
            W_BLOCK: if (!r_full[r_wr_buf])              w_wr_state_nxt = W_FILL;
            default: w_wr_state_nxt = W_FILL;
        endcase
        case (r_rd_state)
            R_IDLE:  if (r_full[r_rd_buf]) w_rd_state_nxt = R_DRAIN;
            R_DRAIN: if (w_rd_last)        w_rd_state_nxt = R_IDLE;
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    // Writer and reader always touch different banks, so set and clear never collide.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_full    <= 2'b00;
            r_wr_buf  <= 1'b0;
            r_rd_buf  <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
        end else begin
            r_wr_done <= w_wr_last;
            r_rd_done <= w_rd_last;
            if (w_wr_last) begin
                r_full[r_wr_buf] <= 1'b1;
                r_wr_buf         <= ~r_wr_buf;
            end
            if (w_rd_last) begin
                r_full[r_rd_buf] <= 1'b0;
                r_rd_buf         <= ~r_rd_buf;
            end
            if (wr_restart || w_wr_last)
                r_wr_cnt <= '0;
            else if (w_wr_ack)
                r_wr_cnt <= r_wr_cnt + c_one;
            if (w_rd_last)
                r_rd_cnt <= '0;
            else if (w_rd_ack)
                r_rd_cnt <= r_rd_cnt + c_one;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (!reset)
            assert (!(w_wr_ack && w_rd_ack && (r_wr_buf == r_rd_buf)));
    end

    assign wr_ack        = w_wr_ack;
    assign rd_ack        = w_rd_ack;
    assign mem_wr_en     = w_wr_ack;
    assign mem_rd_en     = w_rd_ack;
    assign mem_wr_addr   = {r_wr_buf, r_wr_cnt};
    assign mem_rd_addr   = {r_rd_buf, r_rd_cnt};
    assign wr_frame_done = r_wr_done;
    assign rd_frame_done = r_rd_done;
    assign full_cnt      = {1'b0, r_full[0]} + {1'b0, r_full[1]};

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buf_sched
// Description : Directed plus randomized bench for frame_buf_sched against a
//               cycle-level behavioural model of the two-bank scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buf_sched;

    localparam int AW = 2;
    localparam int BS = 4;

    logic          wr_clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_req = 1'b0;
    logic          wr_restart = 1'b0;
    logic          rd_req = 1'b0;
    logic          wr_ack, rd_ack, mem_wr_en, mem_rd_en;
    logic [AW:0]   mem_wr_addr, mem_rd_addr;
    logic          wr_frame_done, rd_frame_done;
    logic [1:0]    full_cnt;

    frame_buf_sched #(.ADDR_WIDTH(AW), .BUF_SIZE(BS)) dut (
        .wr_clk        (wr_clk),
        .reset         (reset),
        .wr_req        (wr_req),
        .wr_restart    (wr_restart),
        .rd_req        (rd_req),
        .wr_ack        (wr_ack),
        .rd_ack        (rd_ack),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr   (mem_wr_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .wr_frame_done (wr_frame_done),
        .rd_frame_done (rd_frame_done),
        .full_cnt      (full_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: bank occupancy, producer/consumer positions, stall flags.
    int m_wb = 0, m_rb = 0, m_wc = 0, m_rc = 0;
    int m_full[2] = '{0, 0};
    int m_wblk = 0, m_rgo = 0, m_wdone = 0, m_rdone = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        int  exp_w, exp_r, wlast, rlast;
        @(negedge wr_clk);
        exp_w = (!reset && wr_req && !wr_restart && !m_wblk && !m_full[m_wb]) ? 1 : 0;
        exp_r = (!reset && rd_req && m_rgo) ? 1 : 0;
        chk("wr_ack", 32'(wr_ack), exp_w);
        chk("mem_wr_en", 32'(mem_wr_en), exp_w);
        chk("rd_ack", 32'(rd_ack), exp_r);
        chk("mem_rd_en", 32'(mem_rd_en), exp_r);
        chk("mem_wr_addr", 32'(mem_wr_addr), m_wb * BS + m_wc);
        chk("mem_rd_addr", 32'(mem_rd_addr), m_rb * BS + m_rc);
        chk("wr_frame_done", 32'(wr_frame_done), m_wdone);
        chk("rd_frame_done", 32'(rd_frame_done), m_rdone);
        chk("full_cnt", 32'(full_cnt), m_full[0] + m_full[1]);
        @(posedge wr_clk);
        if (reset) begin
            m_wb = 0; m_rb = 0; m_wc = 0; m_rc = 0;
            m_full[0] = 0; m_full[1] = 0;
            m_wblk = 0; m_rgo = 0; m_wdone = 0; m_rdone = 0;
        end else begin
            wlast = (exp_w && m_wc == BS - 1) ? 1 : 0;
            rlast = (exp_r && m_rc == BS - 1) ? 1 : 0;
            if (m_wblk) m_wblk = m_full[m_wb];
            else if (wlast && m_full[1 - m_wb]) m_wblk = 1;
            if (rlast) m_rgo = 0;
            else if (!m_rgo && m_full[m_rb]) m_rgo = 1;
            if (wlast) m_full[m_wb] = 1;
            if (rlast) m_full[m_rb] = 0;
            if (wr_restart) m_wc = 0;
            else if (exp_w) m_wc = (m_wc + 1) % BS;
            if (exp_r) m_rc = (m_rc + 1) % BS;
            if (wlast) m_wb = 1 - m_wb;
            if (rlast) m_rb = 1 - m_rb;
            m_wdone = wlast;
            m_rdone = rlast;
        end
        #1;
    endtask

    initial begin
        int pw, pr;
        // Reset state
        repeat (2) tick();
        chk("rst_full_cnt", 32'(full_cnt), 0);

        // Fill after reset, then simultaneous completion of bank 1 write and bank 0 read
        reset = 1'b0; wr_req = 1'b1;
        repeat (4) tick();
        wr_req = 1'b0;
        #1;
        chk("fill_wdone", 32'(wr_frame_done), 1);
        chk("fill_full_cnt", 32'(full_cnt), 1);
        tick();
        rd_req = 1'b1; wr_req = 1'b1;
        #1;
        chk("fill_first_rd_ack", 32'(rd_ack), 1);
        chk("fill_first_rd_addr", 32'(mem_rd_addr), 0);
        repeat (4) tick();
        wr_req = 1'b0; rd_req = 1'b0;
        #1;
        chk("simul_wdone", 32'(wr_frame_done), 1);
        chk("simul_rdone", 32'(rd_frame_done), 1);
        chk("simul_full_cnt", 32'(full_cnt), 1);
        tick();

        // Writer stalls with both banks full, then unblocks as reader drains
        reset = 1'b1; tick();
        reset = 1'b0; wr_req = 1'b1;
        repeat (10) tick();
        #1;
        chk("stall_full_cnt", 32'(full_cnt), 2);
        chk("stall_no_ack", 32'(wr_ack), 0);
        rd_req = 1'b1;
        repeat (5) tick();
        #1;
        chk("unblock_wr_ack", 32'(wr_ack), 1);
        chk("unblock_wr_addr", 32'(mem_wr_addr), 0);
        repeat (9) tick();

        // Restart overrides a simultaneous request
        wr_req = 1'b0; rd_req = 1'b0; reset = 1'b1; tick();
        reset = 1'b0; wr_req = 1'b1;
        repeat (2) tick();
        wr_restart = 1'b1;
        #1;
        chk("restart_no_ack", 32'(wr_ack), 0);
        tick();
        wr_restart = 1'b0;
        #1;
        chk("restart_ack", 32'(wr_ack), 1);
        chk("restart_addr", 32'(mem_wr_addr), 0);
        repeat (4) tick();

        // Reset in the middle of a read frame
        rd_req = 1'b1;
        repeat (3) tick();
        reset = 1'b1; tick();
        #1;
        chk("midrst_full_cnt", 32'(full_cnt), 0);
        chk("midrst_wdone", 32'(wr_frame_done), 0);
        chk("midrst_rdone", 32'(rd_frame_done), 0);
        chk("midrst_wr_addr", 32'(mem_wr_addr), 0);
        chk("midrst_rd_addr", 32'(mem_rd_addr), 0);
        reset = 1'b0;
        #1;
        chk("midrst_first_wr_ack", 32'(wr_ack), 1);
        chk("midrst_first_wr_addr", 32'(mem_wr_addr), 0);
        tick();

        // Randomized traffic with shifting request densities
        for (int blk = 0; blk < 8; blk++) begin
            pw = $urandom_range(1, 4);
            pr = $urandom_range(1, 4);
            for (int i = 0; i < 200; i++) begin
                wr_req     = ($urandom_range(0, 4) < pw);
                rd_req     = ($urandom_range(0, 4) < pr);
                wr_restart = ($urandom_range(0, 40) == 0);
                reset      = ($urandom_range(0, 400) == 0);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
